// File: rtl/uart_tx_if.sv
// Bridge-side register bus for the UART transmitter: word address, write strobe/data,
// combinational read data and the level interrupt back to the CPU.
interface uart_tx_if;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/CTRL/DIVISOR registers, a small TX FIFO
// and a baud-divided shift FSM driving a registered txd line.
module uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RESET  = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     txd
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [1:0]    ctrl;
  logic [15:0]   divisor;
  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [15:0]   baud_cnt;

  logic [1:0]  sel;
  logic        full, empty, push, pop, push_ok;
  logic [15:0] div_m1;
  logic        unused_bits;

  assign sel     = bus.Addr[3:2];
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push    = bus.WE && (sel == 2'd0);
  assign pop     = (state == IDLE) && ctrl[0] && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok = push && (!full || pop);
  // DIVISOR 0 behaves as 1: the per-bit counter reload is clamped at 0
  assign div_m1  = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;

  assign unused_bits = ^{bus.Addr[31:4], bus.Din[31:16]};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ctrl     <= 2'b00;
      divisor  <= 16'(DIV_RESET);
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (bus.WE && sel == 2'd1)  overflow <= 1'b0;
      else if (push && !push_ok)  overflow <= 1'b1;
      if (bus.WE && sel == 2'd2)  ctrl     <= bus.Din[1:0];
      if (bus.WE && sel == 2'd3)  divisor  <= bus.Din[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.Din[7:0];
  end

  // Each bit lasts div_m1+1 cycles; the reload at every bit boundary picks up the live DIVISOR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            bit_cnt  <= '0;
            baud_cnt <= div_m1;
            txd      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt != 16'd0) baud_cnt <= baud_cnt - 16'd1;
          else begin
            baud_cnt <= div_m1;
            txd      <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            state    <= DATA;
          end
        end
        DATA: begin
          if (baud_cnt != 16'd0) baud_cnt <= baud_cnt - 16'd1;
          else begin
            baud_cnt <= div_m1;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd     <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        STOP: begin
          if (baud_cnt != 16'd0) baud_cnt <= baud_cnt - 16'd1;
          else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Dout = '0;
    case (sel)
      2'd1:    bus.Dout = {23'd0, 5'(count), overflow, empty, full, state != IDLE};
      2'd2:    bus.Dout = {30'd0, ctrl};
      2'd3:    bus.Dout = {16'd0, divisor};
      default: bus.Dout = '0;
    endcase
  end

  assign bus.IRQ = ctrl[1] && empty && (state == IDLE);
endmodule
